// File: rtl/reg_bank_pkg.sv
// Shared defaults for the parameterised register bank and its reservation scoreboard.
package reg_bank_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by a granted reservation and cleared by a write.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int DEPTH    = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy_bits,
  output logic              rsv_ack,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_cleared;
  logic [DEPTH-1:0] busy_d;
  logic             grant;
  logic [ADDR_W:0]  cnt_d;

  // The write clears first, so a same-cycle reservation of the same register sees it free.
  always_comb begin
    busy_cleared = busy_q;
    if (wr_en) busy_cleared[wr_addr] = 1'b0;
    grant = rsv_en && !busy_cleared[rsv_addr] && !(ZERO_REG != 0 && rsv_addr == '0);
    busy_d = busy_cleared;
    if (grant) busy_d[rsv_addr] = 1'b1;
    cnt_d = busy_cnt;
    if (wr_en && busy_q[wr_addr]) cnt_d = cnt_d - CNT_ONE;
    if (grant) cnt_d = cnt_d + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= '0;
      rsv_ack  <= 1'b0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      rsv_ack  <= grant;
      busy_cnt <= cnt_d;
    end
  end

  assign busy_bits = busy_q;

endmodule

// File: rtl/reg_bank_param.sv
// Dual-read, single-write register bank with optional write bypass, hardwired zero register
// and a destination-reservation scoreboard.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ack,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_bits;
  logic              wr_ok;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_bits (busy_bits),
    .rsv_ack   (rsv_ack),
    .busy_cnt  (busy_cnt)
  );

  // Read value selection: the zero register overrides everything, then optional write forwarding.
  always_comb begin
    wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    fwd_a = mem[rd_addr_a];
    fwd_b = mem[rd_addr_b];
    if (BYPASS != 0 && wr_ok && wr_addr == rd_addr_a) fwd_a = wr_data;
    if (BYPASS != 0 && wr_ok && wr_addr == rd_addr_b) fwd_b = wr_data;
    if (ZERO_REG != 0 && rd_addr_a == '0) fwd_a = '0;
    if (ZERO_REG != 0 && rd_addr_b == '0) fwd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_busy_a <= 1'b0;
      rd_busy_b <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= fwd_a;
        rd_data_b <= fwd_b;
        rd_busy_a <= busy_bits[rd_addr_a];
        rd_busy_b <= busy_bits[rd_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench driving three reg_bank_param variants (default, no bypass, zero register) in lockstep.
module tb_reg_bank_param;

  typedef struct {
    logic [15:0] da;
    logic [15:0] db;
    logic        ba;
    logic        bb;
    logic        v;
    logic        ack;
    logic [4:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [15:0] rda [3];
  logic [15:0] rdb [3];
  logic        rba [3];
  logic        rbb [3];
  logic        rv  [3];
  logic        ack [3];
  logic [4:0]  cnt [3];

  int compared;
  int mismatched;

  exp_t        exp_q [$];
  logic [15:0] mreg  [3][16];
  logic        mbusy [3][16];
  exp_t        mout  [3];

  reg_bank_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_busy_a(rba[0]), .rd_busy_b(rbb[0]),
    .rd_valid(rv[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ack[0]), .busy_cnt(cnt[0]));

  reg_bank_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_busy_a(rba[1]), .rd_busy_b(rbb[1]),
    .rd_valid(rv[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ack[1]), .busy_cnt(cnt[1]));

  reg_bank_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_zero (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .rd_busy_a(rba[2]), .rd_busy_b(rbb[2]),
    .rd_valid(rv[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ack[2]), .busy_cnt(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model step for variant k, taken on the edge that samples the current inputs.
  task automatic modelStep(input int k);
    bit z;
    bit byp;
    int n;
    z   = (k == 2);
    byp = (k != 1);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 1'b0;
      end
      mout[k] = '{da: '0, db: '0, ba: 1'b0, bb: 1'b0, v: 1'b0, ack: 1'b0, cnt: '0};
    end else begin
      mout[k].v = rd_en;
      if (rd_en) begin
        if (z && rd_addr_a == 0) mout[k].da = '0;
        else if (byp && wr_en && wr_addr == rd_addr_a && !(z && wr_addr == 0)) mout[k].da = wr_data;
        else mout[k].da = mreg[k][rd_addr_a];
        if (z && rd_addr_b == 0) mout[k].db = '0;
        else if (byp && wr_en && wr_addr == rd_addr_b && !(z && wr_addr == 0)) mout[k].db = wr_data;
        else mout[k].db = mreg[k][rd_addr_b];
        mout[k].ba = mbusy[k][rd_addr_a];
        mout[k].bb = mbusy[k][rd_addr_b];
      end
      if (wr_en && !(z && wr_addr == 0)) mreg[k][wr_addr] = wr_data;
      if (wr_en) mbusy[k][wr_addr] = 1'b0;
      mout[k].ack = 1'b0;
      if (rsv_en && !(z && rsv_addr == 0) && !mbusy[k][rsv_addr]) begin
        mbusy[k][rsv_addr] = 1'b1;
        mout[k].ack = 1'b1;
      end
      n = 0;
      for (int i = 0; i < 16; i++) if (mbusy[k][i]) n++;
      mout[k].cnt = 5'(n);
    end
    exp_q.push_back(mout[k]);
  endtask

  task automatic checkOutput();
    exp_t e;
    string nm;
    for (int k = 0; k < 3; k++) begin
      nm = (k == 0) ? "def" : (k == 1) ? "nobyp" : "zero";
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL %s_queue observed=empty expected=entry", nm);
      end else begin
        e = exp_q.pop_front();
        cmp({nm, "_rd_data_a"}, 32'(rda[k]), 32'(e.da));
        cmp({nm, "_rd_data_b"}, 32'(rdb[k]), 32'(e.db));
        cmp({nm, "_rd_busy_a"}, 32'(rba[k]), 32'(e.ba));
        cmp({nm, "_rd_busy_b"}, 32'(rbb[k]), 32'(e.bb));
        cmp({nm, "_rd_valid"},  32'(rv[k]),  32'(e.v));
        cmp({nm, "_rsv_ack"},   32'(ack[k]), 32'(e.ack));
        cmp({nm, "_busy_cnt"},  32'(cnt[k]), 32'(e.cnt));
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rde, input logic [3:0] ra,
                               input logic [3:0] rb, input logic we, input logic [3:0] wa,
                               input logic [15:0] wd, input logic rse, input logic [3:0] rsa);
    rst_n     = rst;
    rd_en     = rde;
    rd_addr_a = ra;
    rd_addr_b = rb;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsv_en    = rse;
    rsv_addr  = rsa;
    for (int k = 0; k < 3; k++) modelStep(k);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 1, 2, 1, 1, 16'h5555, 1, 1);

    // Write then read r5
    applyStimulus(1, 0, 0, 0, 1, 5, 16'hBEEF, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 16'h0, 0, 0);
    cmp("req033_data", 32'(rda[0]), 32'hBEEF);
    cmp("req033_valid", 32'(rv[0]), 32'h1);
    applyStimulus(1, 0, 3, 3, 0, 0, 16'h0, 0, 0);
    cmp("hold_data", 32'(rda[0]), 32'hBEEF);

    // Same-cycle write/read forwarding on port b
    applyStimulus(1, 0, 0, 0, 1, 3, 16'h1111, 0, 0);
    applyStimulus(1, 1, 5, 3, 1, 3, 16'h1234, 0, 0);
    cmp("req034_bypass", 32'(rdb[0]), 32'h1234);
    cmp("req034_nobypass", 32'(rdb[1]), 32'h1111);

    // Zero register ignores writes and reservations
    applyStimulus(1, 0, 0, 0, 1, 0, 16'hFFFF, 1, 0);
    cmp("req035_ack", 32'(ack[2]), 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 16'h0, 0, 0);
    cmp("req035_data", 32'(rda[2]), 32'h0);
    cmp("req035_cnt", 32'(cnt[2]), 32'h0);

    // Reservation conflicts on r7
    applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 1, 7);
    cmp("req036_ack1", 32'(ack[2]), 32'h1);
    cmp("req036_cnt1", 32'(cnt[2]), 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 1, 7);
    cmp("req036_ack2", 32'(ack[2]), 32'h0);
    applyStimulus(1, 1, 7, 7, 1, 7, 16'hA5A5, 1, 7);
    cmp("req036_ack3", 32'(ack[2]), 32'h1);
    cmp("req036_cnt3", 32'(cnt[2]), 32'h1);
    cmp("req026_busy", 32'(rba[2]), 32'h1);

    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                    16'($urandom), 1'($urandom), 4'($urandom));

    // Fill the scoreboard to full depth
    for (int i = 0; i < 16; i++)
      applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 1, 4'(i));
    cmp("req037_full_def", 32'(cnt[0]), 32'd16);
    cmp("req037_full_zero", 32'(cnt[2]), 32'd15);

    applyStimulus(0, 1, 5, 3, 1, 2, 16'h7777, 1, 2);
    cmp("req037_rst_cnt", 32'(cnt[0]), 32'h0);
    cmp("req037_rst_data", 32'(rda[0]), 32'h0);
    cmp("req037_rst_valid", 32'(rv[0]), 32'h0);

    // First cycle after reset behaves normally
    applyStimulus(1, 1, 9, 5, 1, 9, 16'hC0DE, 1, 9);
    cmp("req029_data", 32'(rda[0]), 32'hC0DE);
    cmp("req029_oldval", 32'(rdb[0]), 32'h0);
    applyStimulus(1, 1, 9, 9, 0, 0, 16'h0, 0, 0);

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
